alu_multicycle: RTL and testbench

Parametrised, handshaked successor to the single-cycle 32-bit ALU. It adds iterative signed multiply and divide alongside the existing add, sub, and, or, sll and sra operations. Results and flags are registered behind a valid/ready pair, so the block can sit directly in a pipelined datapath stage. Producers and consumers stall it through backpressure.

---
 rtl/alu_multicycle.sv | 189 ++++++++++++++++++
 tb/tb_alu_multicycle.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Purpose : handshaked signed ALU: add/sub/and/or/sll/sra in one cycle, iterative mul/div.
// Latency : 1 cycle for single-cycle ops, div-by-zero and illegal opcodes; WIDTH+1 cycles for mul/div.
// Backpr. : in_ready drops while iterating or while a result is held with out_ready low;
//           held results never get overwritten.
// Ports   : clock/reset_n (async active-low); in_valid/in_ready with data_operandA/B,
//           ctrl_ALUopcode, ctrl_shiftamt; out_valid/out_ready with data_result and the
//           isNotEqual/isLessThan/overflow/exception flags.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0]       ctrl_ALUopcode,
  input  logic [SHW-1:0]   ctrl_shiftamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             isNotEqual,
  output logic             isLessThan,
  output logic             overflow,
  output logic             exception
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [SHW-1:0]   LAST    = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR  = 5'd3,
                         OP_SLL = 5'd4, OP_SRA = 5'd5, OP_MUL = 5'd6, OP_DIV = 5'd7;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [W2:0]      work_q, work_d;   // mul: {partial sum, multiplier}; div: {0, remainder, quotient}
  logic [SHW-1:0]   cnt_q, cnt_d;

  logic             accept, out_free, load;
  logic [WIDTH-1:0] res_d;
  logic             ovf_d, exc_d, ne_d, lt_d;

  logic [WIDTH-1:0] cmp_a, cmp_b, sum, diff, mag_b, rem_new, quo_s;
  logic             add_ovf, sub_ovf, flag_ne, flag_lt, neg, div_ge;
  logic [WIDTH:0]   mul_hi, rem_sh;
  logic [W2:0]      mul_next, div_next;
  logic [W2-1:0]    prod_s;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    mag = v[WIDTH-1] ? -v : v;
  endfunction

  assign out_free = !out_valid || out_ready;
  assign in_ready = (state_q == S_IDLE) && out_free;
  assign accept   = in_valid && in_ready;

  // Flags come from the live inputs while idle (they are captured on that same edge)
  // and from the captured operands once an iterative op is in flight.
  assign cmp_a   = (state_q == S_IDLE) ? data_operandA : a_q;
  assign cmp_b   = (state_q == S_IDLE) ? data_operandB : b_q;
  assign sum     = cmp_a + cmp_b;
  assign diff    = cmp_a - cmp_b;
  assign add_ovf = (cmp_a[WIDTH-1] == cmp_b[WIDTH-1]) && (sum[WIDTH-1]  != cmp_a[WIDTH-1]);
  assign sub_ovf = (cmp_a[WIDTH-1] != cmp_b[WIDTH-1]) && (diff[WIDTH-1] != cmp_a[WIDTH-1]);
  assign flag_ne = (cmp_a != cmp_b);
  assign flag_lt = diff[WIDTH-1] ^ sub_ovf;

  // One radix-2 step each for multiply and restoring divide, on magnitudes.
  assign mag_b    = mag(b_q);
  assign neg      = a_q[WIDTH-1] ^ b_q[WIDTH-1];
  assign mul_hi   = work_q[W2:WIDTH] + (work_q[0] ? {1'b0, mag_b} : '0);
  assign mul_next = {mul_hi, work_q[WIDTH-1:0]} >> 1;
  assign rem_sh   = work_q[W2-1:WIDTH-1];
  assign div_ge   = rem_sh >= {1'b0, mag_b};
  assign rem_new  = WIDTH'(div_ge ? rem_sh - {1'b0, mag_b} : rem_sh);
  assign div_next = {1'b0, rem_new, work_q[WIDTH-2:0], div_ge};
  assign prod_s   = neg ? -mul_next[W2-1:0] : mul_next[W2-1:0];
  assign quo_s    = neg ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    res_d   = '0;
    ovf_d   = 1'b0;
    exc_d   = 1'b0;
    ne_d    = flag_ne;
    lt_d    = flag_lt;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          load = 1'b1;
          case (ctrl_ALUopcode)
            OP_ADD: begin res_d = sum;  ovf_d = add_ovf; end
            OP_SUB: begin res_d = diff; ovf_d = sub_ovf; end
            OP_AND: res_d = data_operandA & data_operandB;
            OP_OR:  res_d = data_operandA | data_operandB;
            OP_SLL: res_d = data_operandA << ctrl_shiftamt;
            OP_SRA: res_d = $signed(data_operandA) >>> ctrl_shiftamt;
            OP_MUL: begin
              load    = 1'b0;
              state_d = S_MUL;
              work_d  = {{(WIDTH+1){1'b0}}, mag(data_operandA)};
              cnt_d   = '0;
            end
            OP_DIV: begin
              if (data_operandB == '0) begin
                exc_d = 1'b1;
              end else begin
                load    = 1'b0;
                state_d = S_DIV;
                work_d  = {{(WIDTH+1){1'b0}}, mag(data_operandA)};
                cnt_d   = '0;
              end
            end
            default: begin
              exc_d = 1'b1;
              ne_d  = 1'b0;
              lt_d  = 1'b0;
            end
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q != LAST) begin
          work_d = (state_q == S_MUL) ? mul_next : div_next;
          cnt_d  = cnt_q + 1'b1;
        end else if (out_free) begin
          // Last step and sign fix-up land straight in the output registers;
          // otherwise sit here untouched until the held result is taken.
          load    = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
          if (state_q == S_MUL) begin
            res_d = prod_s[WIDTH-1:0];
            ovf_d = prod_s[W2-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}};
          end else begin
            res_d = quo_s;
            ovf_d = (a_q == MIN_VAL) && (b_q == '1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q         <= '0;
      b_q         <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      out_valid   <= 1'b0;
      data_result <= '0;
      isNotEqual  <= 1'b0;
      isLessThan  <= 1'b0;
      overflow    <= 1'b0;
      exception   <= 1'b0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      if (accept) begin
        a_q <= data_operandA;
        b_q <= data_operandB;
      end
      if (load) begin
        out_valid   <= 1'b1;
        data_result <= res_d;
        isNotEqual  <= ne_d;
        isLessThan  <= lt_d;
        overflow    <= ovf_d;
        exception   <= exc_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Purpose : self-checking bench for alu_multicycle (WIDTH=32) using an expected-result queue.
// Latency : checks 1-cycle ops, 33-cycle mul/div, back-to-back issue and reset abort.
// Backpr. : exercises held results under out_ready=0 and random consumer stalls.
module tb_alu_multicycle;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_operandA, data_operandB;
  logic [4:0]  ctrl_ALUopcode;
  logic [4:0]  ctrl_shiftamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_result;
  logic        isNotEqual, isLessThan, overflow, exception;

  alu_multicycle dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_ALUopcode (ctrl_ALUopcode),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .data_result    (data_result),
    .isNotEqual     (isNotEqual),
    .isLessThan     (isLessThan),
    .overflow       (overflow),
    .exception      (exception)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;   // {ne, lt, ovf, exc}
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint sx(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] op, input logic [4:0] sh);
    exp_t   e;
    longint full;
    logic   ne, lt, ovf, exc;
    ne  = (a != b);
    lt  = sx(a) < sx(b);
    ovf = 1'b0;
    exc = 1'b0;
    e.res = '0;
    case (op)
      5'd0: begin full = sx(a) + sx(b); e.res = full[31:0]; ovf = full != sx(e.res); end
      5'd1: begin full = sx(a) - sx(b); e.res = full[31:0]; ovf = full != sx(e.res); end
      5'd2: e.res = a & b;
      5'd3: e.res = a | b;
      5'd4: e.res = a << sh;
      5'd5: e.res = 32'($signed(a) >>> sh);
      5'd6: begin full = sx(a) * sx(b); e.res = full[31:0]; ovf = full != sx(e.res); end
      5'd7: begin
        if (b == 32'd0) exc = 1'b1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin e.res = a; ovf = 1'b1; end
        else begin full = sx(a) / sx(b); e.res = full[31:0]; end
      end
      default: begin exc = 1'b1; ne = 1'b0; lt = 1'b0; end
    endcase
    e.fl = {ne, lt, ovf, exc};
    return e;
  endfunction

  // Scoreboard: pop on an output handshake, push on an input handshake.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("result", data_result, e.res);
        chk("flags", {isNotEqual, isLessThan, overflow, exception}, e.fl);
      end
    end
    if (reset_n && in_valid && in_ready)
      sb.push_back(model(data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt));
  end

  always @(posedge clock) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  // Drives one request and returns the cycle index of the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                      input logic [4:0] sh, output int acc);
    int n = 0;
    in_valid       = 1'b1;
    data_operandA  = a;
    data_operandB  = b;
    ctrl_ALUopcode = op;
    ctrl_shiftamt  = sh;
    @(negedge clock);
    while (!in_ready && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) chk("accept_timeout", in_ready, 1'b1);
    @(posedge clock);
    #1;
    acc            = cyc;
    in_valid       = 1'b0;
    data_operandA  = $urandom;
    data_operandB  = $urandom;
  endtask

  task automatic wait_out(input int acc, input int exp_lat, input bit busy);
    int n = 0;
    bit ready_seen = 1'b0;
    @(negedge clock);
    while (!out_valid && n < 100) begin
      if (in_ready) ready_seen = 1'b1;
      n++;
      @(negedge clock);
    end
    chk("latency", 64'(cyc - acc + 1), 64'(exp_lat));
    if (busy) chk("in_ready_while_busy", ready_seen, 1'b0);
    @(posedge clock);
    #1;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                     input int exp_lat);
    int acc;
    send(a, b, op, 5'd0, acc);
    wait_out(acc, exp_lat, exp_lat > 1);
  endtask

  initial begin
    int acc;
    int n;
    reset_n        = 1'b0;
    in_valid       = 1'b0;
    data_operandA  = '0;
    data_operandB  = '0;
    ctrl_ALUopcode = '0;
    ctrl_shiftamt  = '0;
    out_ready      = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", data_result, 32'd0);
    chk("rst_flags", {isNotEqual, isLessThan, overflow, exception}, 4'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clock);
    #1;

    // Single-cycle arithmetic and flags.
    run(32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1);
    run(32'h8000_0000, 32'h0F00_0000, 5'd1, 1);
    run(32'h8000_0001, 32'h7FFF_FFFF, 5'd1, 1);
    run(32'hF0F0_1234, 32'h0FF0_FFFF, 5'd2, 1);
    send(32'h8000_00F1, 32'h0, 5'd4, 5'd4, acc);
    wait_out(acc, 1, 1'b0);
    send(32'h8000_00F1, 32'h0, 5'd5, 5'd31, acc);
    wait_out(acc, 1, 1'b0);
    run(32'h0000_0005, 32'h0000_0009, 5'd9, 1);

    // Back-to-back issue.
    for (int i = 0; i < 4; i++) begin
      in_valid       = 1'b1;
      data_operandA  = 32'd1 << i;
      data_operandB  = 32'd1 << i;
      ctrl_ALUopcode = 5'd0;
      @(negedge clock);
      chk("b2b_in_ready", in_ready, 1'b1);
      if (i > 0) chk("b2b_out_valid", out_valid, 1'b1);
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clock);
    chk("b2b_last_valid", out_valid, 1'b1);
    @(posedge clock);
    #1;

    // Iterative multiply and divide.
    run(32'hFFFF_FFFD, 32'h0000_0007, 5'd6, 33);
    run(32'h0001_0000, 32'h0001_0000, 5'd6, 33);
    run(32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 33);
    run(32'hFFFF_FFF9, 32'h0000_0002, 5'd7, 33);
    run(32'h0000_0005, 32'h0000_0000, 5'd7, 1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 33);
    run(32'h0000_0064, 32'hFFFF_FFF9, 5'd7, 33);

    // Backpressure: held result stays put.
    out_ready = 1'b0;
    send(32'hF0F0_0000, 32'h0000_FFFF, 5'd3, 5'd0, acc);
    repeat (5) begin
      @(negedge clock);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_result", data_result, 32'hF0F0_FFFF);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_in_ready", in_ready, 1'b1);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("bp_drained", out_valid, 1'b0);
    chk("bp_in_ready_after", in_ready, 1'b1);
    @(posedge clock);
    #1;

    // Reset in the middle of a multiply.
    send(32'h0000_1234, 32'h0000_0567, 5'd6, 5'd0, acc);
    repeat (10) @(posedge clock);
    #1 reset_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_result", data_result, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    chk("abort_no_stale", out_valid, 1'b0);
    chk("abort_in_ready", in_ready, 1'b1);
    run(32'd2, 32'd3, 5'd0, 1);

    // Random mix with a stalling consumer.
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($signed($urandom) >>> $urandom_range(0, 30));
      send(a, b, 5'($urandom_range(0, 8)), 5'($urandom_range(0, 31)), acc);
    end
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    rand_rdy = 1'b0;
    repeat (2) @(posedge clock);
    #1 out_ready = 1'b1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
